// File: rtl/mux4to1_rr_n_bit_if.sv
// Handshake bundle for the 4:1 round-robin gather mux.
// Four N-bit producers (a0..a3 with a_valid/a_ready) and one N-bit
// consumer stream (z/z_valid/z_ready) plus the 2-bit source index s.
// master: the mux itself (drives a_ready, z, z_valid, s).
// slave : the surrounding producers/consumer.
interface mux4to1_rr_n_bit_if #(
    parameter int N = 8
);
    logic [N-1:0] a0;
    logic [N-1:0] a1;
    logic [N-1:0] a2;
    logic [N-1:0] a3;
    logic [3:0]   a_valid;
    logic [3:0]   a_ready;
    logic [N-1:0] z;
    logic         z_valid;
    logic         z_ready;
    logic [1:0]   s;

    modport master (
        input  a0, a1, a2, a3, a_valid, z_ready,
        output a_ready, z, z_valid, s
    );

    modport slave (
        output a0, a1, a2, a3, a_valid, z_ready,
        input  a_ready, z, z_valid, s
    );
endinterface

// File: rtl/mux4to1_rr_n_bit.sv
// 4:1 N-bit gather mux with round-robin arbitration and a registered
// output stage carrying the data word and its 2-bit source index.
// Build option: define MUX_FIXED_PRIO_EN for fixed priority (source 0
// highest, no rotating pointer). Default build is round-robin.
module mux4to1_rr_n_bit #(
    parameter int N = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    mux4to1_rr_n_bit_if.master       bus
);
    logic [1:0]   start;
    logic [1:0]   winner;
    logic         any_valid;
    logic         load;
    logic         accept;
    logic [N-1:0] win_data;

    logic [N-1:0] z_q;
    logic [1:0]   s_q;
    logic         z_valid_q;

`ifdef MUX_FIXED_PRIO_EN
    // Search always begins at source 0, so the lowest index wins.
    assign start = 2'b00;
`else
    logic [1:0]   ptr;
    // Search begins one past the last granted source.
    assign start = ptr;
`endif

    assign any_valid = |bus.a_valid;
    // Output register can take a word when empty or being drained now.
    assign load      = !z_valid_q || bus.z_ready;
    assign accept    = !rst && load && any_valid;

    // Circular search from start; walking downwards means the closest
    // valid source to start is the last one written and therefore wins.
    always_comb begin
        logic [1:0] idx;
        idx    = 2'b00;
        winner = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (bus.a_valid[idx]) begin
                winner = idx;
            end
        end
    end

    // Select the winning source's data word.
    always_comb begin
        win_data = bus.a0;
        case (winner)
            2'd0:    win_data = bus.a0;
            2'd1:    win_data = bus.a1;
            2'd2:    win_data = bus.a2;
            default: win_data = bus.a3;
        endcase
    end

    // One-hot grant; never more than one bit set, all zero in reset.
    assign bus.a_ready = accept ? (4'b0001 << winner) : 4'b0000;

    // Output register: load on accept, drop valid on a drain with no new
    // word; z and s keep their last values after a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_valid_q <= 1'b0;
            z_q       <= '0;
            s_q       <= 2'b00;
`ifndef MUX_FIXED_PRIO_EN
            ptr       <= 2'b00;
`endif
        end else if (accept) begin
            z_valid_q <= 1'b1;
            z_q       <= win_data;
            s_q       <= winner;
`ifndef MUX_FIXED_PRIO_EN
            ptr       <= winner + 2'd1;
`endif
        end else if (load) begin
            z_valid_q <= 1'b0;
        end
    end

    assign bus.z       = z_q;
    assign bus.s       = s_q;
    assign bus.z_valid = z_valid_q;
endmodule

// File: tb/tb_mux4to1_rr_n_bit.sv
// Self-checking bench for mux4to1_rr_n_bit. A reference model predicts
// grants at the falling edge and queues the expected {s, z}; after the
// rising edge the queue entry is popped and compared with the output.
module tb_mux4to1_rr_n_bit;
    localparam int N = 8;

    logic clk;
    logic rst;

    mux4to1_rr_n_bit_if #(.N(N)) bus();

    mux4to1_rr_n_bit #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [N+1:0] exp_q[$];

    logic         m_zv;
    logic [N-1:0] m_z;
    logic [1:0]   m_s;
    logic [1:0]   m_ptr;
    logic         last_acc;
    logic [1:0]   last_w;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_winner();
        logic [1:0] first;
        logic [1:0] base;
        logic       hit;
`ifdef MUX_FIXED_PRIO_EN
        base = 2'd0;
`else
        base = m_ptr;
`endif
        hit   = 1'b0;
        first = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (!hit && bus.a_valid[(int'(base) + k) % 4]) begin
                hit   = 1'b1;
                first = 2'((int'(base) + k) % 4);
            end
        end
        return first;
    endfunction

    function automatic logic [N-1:0] src_data(input logic [1:0] i);
        case (i)
            2'd0:    return bus.a0;
            2'd1:    return bus.a1;
            2'd2:    return bus.a2;
            default: return bus.a3;
        endcase
    endfunction

    task automatic set_src(input int i, input logic [N-1:0] d);
        case (i)
            0:       bus.a0 = d;
            1:       bus.a1 = d;
            2:       bus.a2 = d;
            default: bus.a3 = d;
        endcase
    endtask

    // One clock: predict/check grant at negedge, check output after posedge.
    task automatic tick();
        logic         ld;
        logic         acc;
        logic [1:0]   w;
        logic [3:0]   exp_rdy;
        logic [N+1:0] e;
        @(negedge clk);
        ld      = !m_zv || bus.z_ready;
        w       = model_winner();
        acc     = !rst && ld && (bus.a_valid != 4'b0000);
        exp_rdy = acc ? (4'b0001 << w) : 4'b0000;
        chk("a_ready", 32'(bus.a_ready), 32'(exp_rdy));
        if (acc) exp_q.push_back({w, src_data(w)});
        @(posedge clk);
        #1;
        if (rst) begin
            m_zv  = 1'b0;
            m_z   = '0;
            m_s   = 2'b00;
            m_ptr = 2'b00;
            exp_q.delete();
        end else if (acc) begin
            if (exp_q.size() == 0) begin
                chk("queue_empty", 32'(1), 32'(0));
            end else begin
                e     = exp_q.pop_front();
                m_z   = e[N-1:0];
                m_s   = e[N+1:N];
                m_zv  = 1'b1;
                m_ptr = w + 2'd1;
            end
        end else if (ld) begin
            m_zv = 1'b0;
        end
        last_acc = acc;
        last_w   = w;
        chk("z_valid", 32'(bus.z_valid), 32'(m_zv));
        chk("z",       32'(bus.z),       32'(m_z));
        chk("s",       32'(bus.s),       32'(m_s));
    endtask

    initial begin
        m_zv = 1'b0; m_z = '0; m_s = 2'b00; m_ptr = 2'b00;
        last_acc = 1'b0; last_w = 2'b00;
        rst = 1'b1;
        bus.a0 = 8'h11; bus.a1 = 8'h22; bus.a2 = 8'h33; bus.a3 = 8'h44;
        bus.a_valid = 4'b1111;
        bus.z_ready = 1'b1;

        // Reset held two cycles with every source requesting.
        tick();
        tick();

        // Single source 2.
        rst = 1'b0;
        bus.a_valid = 4'b0100;
        bus.a2 = 8'b11010101;
        tick();
        bus.a_valid = 4'b0000;
        tick();

        // All sources valid, starting from a fresh pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.a2 = 8'h33;
        bus.a_valid = 4'b1111;
        repeat (5) tick();

        // Backpressure: AA from source 1 held, then released.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.a_valid = 4'b0010;
        bus.a1 = 8'hAA;
        tick();
        bus.z_ready = 1'b0;
        bus.a_valid = 4'b1111;
        repeat (3) tick();
        bus.z_ready = 1'b1;
        tick();

        // Wrap from source 3 back to source 0.
        bus.a_valid = 4'b1000;
        tick();
        bus.a_valid = 4'b1001;
        tick();
        tick();

        // Reset while the output holds a stalled word.
        bus.a_valid = 4'b1111;
        bus.z_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.a_valid = 4'b0011;
        bus.z_ready = 1'b1;
        tick();

        // Random traffic with sources holding data until accepted.
        bus.a_valid = 4'b0000;
        tick();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (last_acc && last_w == 2'(i)) bus.a_valid[i] = 1'b0;
                if (!bus.a_valid[i] && $urandom_range(0, 2) != 0) begin
                    bus.a_valid[i] = 1'b1;
                    set_src(i, N'($urandom));
                end
            end
            bus.z_ready = ($urandom_range(0, 3) != 0);
            rst = (c % 97 == 96);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux4to1_rr_n_bit.md
Name: mux4to1_rr_N_bit

Overview:
- Merges four N-bit source streams onto one output stream, each with a valid/ready handshake. It is the inverse of the 4-way N-bit demux.
- A round-robin arbiter picks one pending source per cycle. A registered output stage carries the data together with the 2-bit source index.
- Sits on the gather side of the datapath. The demux fans one stream out to four consumers; this block collects four producers back onto one stream.

Parameters:
- N, 8, data width of every input and of the output.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- a0  input  N  source 0 data.
- a1  input  N  source 1 data.
- a2  input  N  source 2 data.
- a3  input  N  source 3 data.
- a_valid  input  4  bit i high means source i data is valid.
- a_ready  output  4  bit i high means source i is accepted this cycle; combinational.
- z  output  N  registered output data.
- z_valid  output  1  output holds a word.
- z_ready  input  1  downstream accepts the output.
- s  output  2  index of the source that produced z; registered with z.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high. Sampled on the rising edge of clk; overrides all other activity.
- Reset values: z_valid=0, z=0, s=2'b00, round-robin pointer ptr=0. a_ready=0 while rst=1.
- Handshake: a transfer occurs on any edge where valid and ready are both high.
- Load condition: load = !z_valid || z_ready. The output register is empty, or is being drained in the same cycle.
- Arbitration: search a_valid starting at index ptr, wrapping 3->0. The winner w is the first set bit found.
- Grant: a_ready = (load && any a_valid) ? one-hot(w) : 4'b0000. At most one a_ready bit is ever high.
- Accept edge:
  - z<=a_w, s<=w, z_valid<=1.
  - ptr<=(w+1) mod 4; 2-bit wrap, so 3 goes to 0.
- Drain edge (z_valid && z_ready with no pending a_valid): z_valid<=0. z and s keep their last values.
- Latency and throughput: 1 cycle from input handshake to z_valid. Full throughput of 1 word/cycle when z_ready is held high.
- Backpressure (z_valid=1, z_ready=0):
  - z, s and z_valid hold stable.
  - a_ready=0000; ptr unchanged.
- Simultaneous drain and accept: the new word replaces the old one on the same edge, with no bubble.
- No valid inputs: ptr unchanged and a_ready=0000.
- Fairness: a source that stays valid is granted within 4 accepts.
- Source data: a_i is not captured until its handshake. Sources must hold a_i and a_valid[i] stable until accepted.
- Reset mid-operation: any word held in the output register is discarded, not delivered. The arbiter restarts at source 0.
- Widths: all data paths are exactly N bits, with no extension or truncation.

Optional Feature:
- Macro: MUX_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins (source 0 highest). ptr is removed and the search always starts at 0. Fairness is not guaranteed, and a source can starve while a lower index stays valid.
- Not defined: round-robin as described in Behaviour.
- Ports, latency and handshake rules are identical in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles with a_valid=1111 -> z_valid=0, z=8'h00, s=00, a_ready=0000 throughout.
- Single source: a_valid=0100, a2=8'b11010101, z_ready=1 -> a_ready=0100 for one cycle. Next cycle z=8'b11010101, s=10, z_valid=1.
- All sources valid: a0..a3=8'h11,8'h22,8'h33,8'h44, a_valid=1111 held, z_ready=1 -> z=11,22,33,44,11 on consecutive cycles with s=0,1,2,3,0. Under MUX_FIXED_PRIO_EN: z=11 every cycle, s=0.
- Backpressure: word 8'hAA from source 1 held while z_ready=0 for 3 cycles, a_valid=1111 -> z=AA, s=01 stable; a_ready=0000. On release: z_ready=1 -> same edge loads source 2 with no bubble.
- Wrap: grant source 3, then a_valid=1001 -> next grant is source 0, then source 3.
- Reset mid-stream: rst=1 while z_valid=1, z_ready=0 -> next cycle z_valid=0, s=00. First grant after reset with a_valid=0011 is source 0.
